// File: rtl/leon_seq_pkg.sv
// leon_seq_pkg
// Shared types and constants for the LEON stimulus sequencer.
//   seq_op_e    : abstract command opcode (NOP, LOAD, ADD, STORE)
//   seq_cmd_t   : one queued command (opcode, register fields, data)
//   seq_state_e : sequencer FSM states
//   SPARC_*     : SPARC V8 base instruction words before field insertion
// Configuration macro used by the sequencer: LEON_SEQ_STORE_CHECK_EN.
package leon_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_ADD   = 2'd2,
    OP_STORE = 2'd3
  } seq_op_e;

  typedef struct packed {
    seq_op_e     op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] data;
  } seq_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PAD   = 2'd2
  } seq_state_e;

  // sethi 0, %g0
  localparam logic [31:0] SPARC_NOP      = 32'h0100_0000;
  // ld [%g0 + 0], rd
  localparam logic [31:0] SPARC_LD_BASE  = 32'hC000_2000;
  // add rs1, rs2, rd
  localparam logic [31:0] SPARC_ADD_BASE = 32'h8000_0000;
  // st rd, [%g0 + 0]
  localparam logic [31:0] SPARC_ST_BASE  = 32'hC020_2000;

endpackage

// File: rtl/sparc_inst_encoder.sv
// sparc_inst_encoder
// Combinational translation of an abstract command into a SPARC V8
// instruction word. Fields that an opcode does not use are ignored.
// Ports:
//   cmd  in  seq_cmd_t  command to encode
//   inst out 32         encoded instruction word
module sparc_inst_encoder
  import leon_seq_pkg::*;
(
  input  seq_cmd_t    cmd,
  output logic [31:0] inst
);

  always_comb begin
    inst = SPARC_NOP;
    case (cmd.op)
      OP_LOAD:  inst = SPARC_LD_BASE | {2'b00, cmd.rd, 25'd0};
      OP_ADD:   inst = SPARC_ADD_BASE | {2'b00, cmd.rd, 25'd0}
                     | {13'd0, cmd.rs1, 14'd0} | {27'd0, cmd.rs2};
      OP_STORE: inst = SPARC_ST_BASE | {2'b00, cmd.rd, 25'd0};
      default:  inst = SPARC_NOP;
    endcase
  end

endmodule

// File: rtl/leon_stim_sequencer.sv
// leon_stim_sequencer
// Drives the LEON integer unit through its fetch and data-cache ports from a
// FIFO of abstract commands. Each command issues one instruction followed by
// NOP_PAD NOPs; loads return data LD_LAT steps after issue, stores capture the
// first write seen within ST_WIN steps.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake into the FIFO
//   cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, cmd_data_i  command fields
//   hold_i                   pipeline stall, freezes the sequencer
//   inst_o, inst_valid_o     fetch port word and issue strobe
//   ld_data_o, ld_valid_o    load return data and strobe
//   dc_wen_i, dc_wdata_i     store write from the pipeline
//   st_data_o, st_done_o, st_timeout_o  store capture results
//   st_mismatch_o            (LEON_SEQ_STORE_CHECK_EN only) captured != expected
//   busy_o                   FIFO non-empty or FSM active
// Optional feature macro: LEON_SEQ_STORE_CHECK_EN.
module leon_stim_sequencer
  import leon_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NOP_PAD = 4,
  parameter int LD_LAT  = 3,
  parameter int ST_WIN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [4:0]  cmd_rs1_i,
  input  logic [4:0]  cmd_rs2_i,
  input  logic [31:0] cmd_data_i,
  input  logic        hold_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  input  logic        dc_wen_i,
  input  logic [31:0] dc_wdata_i,
  output logic [31:0] st_data_o,
  output logic        st_done_o,
  output logic        st_timeout_o,
`ifdef LEON_SEQ_STORE_CHECK_EN
  output logic        st_mismatch_o,
`endif
  output logic        busy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int K_W   = $clog2(NOP_PAD + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [K_W-1:0]   K_PAD    = K_W'(NOP_PAD);
  localparam logic [K_W-1:0]   K_LD     = K_W'(LD_LAT);
  localparam logic [K_W-1:0]   K_ST     = K_W'(ST_WIN);

  // ---------------- command FIFO ----------------
  seq_cmd_t         fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop;
  seq_cmd_t         in_cmd, head_cmd;
  logic [31:0]      head_inst;

  assign in_cmd = '{op: seq_op_e'(cmd_op_i), rd: cmd_rd_i, rs1: cmd_rs1_i,
                    rs2: cmd_rs2_i, data: cmd_data_i};
  // cmd_ready_o is the registered not-full flag, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign push       = cmd_valid_i && cmd_ready_o;
  assign head_cmd   = fifo_mem[rd_ptr_reg];
  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= in_cmd;
  end

  sparc_inst_encoder u_enc (
    .cmd  (head_cmd),
    .inst (head_inst)
  );

  // ---------------- sequencer state ----------------
  seq_state_e  state_reg, state_next;
  logic [K_W-1:0] k_reg, k_next;
  seq_op_e     cur_op_reg, cur_op_next;
  logic [31:0] cur_data_reg, cur_data_next;
  // A store window is open and no write has been captured yet.
  logic        st_armed_reg, st_armed_next;

  logic [31:0] inst_next, ld_data_next, st_data_next;
  logic        inst_valid_next, ld_valid_next, st_done_next, st_timeout_next;
  logic        ready_next, busy_next;
`ifdef LEON_SEQ_STORE_CHECK_EN
  logic        mismatch_next;
`endif

  always_comb begin
    state_next      = state_reg;
    k_next          = k_reg;
    pop             = 1'b0;
    cur_op_next     = cur_op_reg;
    cur_data_next   = cur_data_reg;
    st_armed_next   = st_armed_reg;
    inst_next       = inst_o;
    inst_valid_next = 1'b0;
    ld_valid_next   = 1'b0;
    ld_data_next    = ld_data_o;
    st_done_next    = 1'b0;
    st_timeout_next = 1'b0;
    st_data_next    = st_data_o;
`ifdef LEON_SEQ_STORE_CHECK_EN
    mismatch_next   = 1'b0;
`endif

    // While held nothing advances and strobes drop; a strobe due on a held
    // step fires once the step is finally taken.
    if (!hold_i) begin
      case (state_reg)
        ST_IDLE: begin
          if (count_reg != '0) begin
            state_next = ST_ISSUE;
            pop        = 1'b1;
            k_next     = '0;
          end
        end
        ST_ISSUE: begin
          state_next = ST_PAD;
          k_next     = K_W'(1);
        end
        ST_PAD: begin
          if (k_reg == K_PAD) begin
            k_next = '0;
            if (count_reg != '0) begin
              state_next = ST_ISSUE;
              pop        = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            k_next = k_reg + K_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase

      inst_next = SPARC_NOP;
      if (pop) begin
        inst_next       = head_inst;
        inst_valid_next = 1'b1;
        cur_op_next     = head_cmd.op;
        cur_data_next   = head_cmd.data;
        st_armed_next   = (head_cmd.op == OP_STORE);
      end

      // Outputs are registered, so events are keyed on the step being entered.
      if (state_next == ST_PAD && k_next == K_LD && cur_op_reg == OP_LOAD) begin
        ld_valid_next = 1'b1;
        ld_data_next  = cur_data_reg;
      end

      if (st_armed_reg && state_next == ST_PAD) begin
        if (dc_wen_i) begin
          st_done_next  = 1'b1;
          st_data_next  = dc_wdata_i;
          st_armed_next = 1'b0;
`ifdef LEON_SEQ_STORE_CHECK_EN
          mismatch_next = (dc_wdata_i != cur_data_reg);
`endif
        end else if (k_next == K_ST) begin
          st_timeout_next = 1'b1;
          st_armed_next   = 1'b0;
        end
      end
    end

    ready_next = (count_next != FULL_CNT);
    busy_next  = (count_next != '0) || (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      cur_op_reg   <= OP_NOP;
      cur_data_reg <= '0;
      st_armed_reg <= 1'b0;
      inst_o       <= SPARC_NOP;
      inst_valid_o <= 1'b0;
      ld_data_o    <= '0;
      ld_valid_o   <= 1'b0;
      st_data_o    <= '0;
      st_done_o    <= 1'b0;
      st_timeout_o <= 1'b0;
      cmd_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
`ifdef LEON_SEQ_STORE_CHECK_EN
      st_mismatch_o <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg    <= count_next;
      cur_op_reg   <= cur_op_next;
      cur_data_reg <= cur_data_next;
      st_armed_reg <= st_armed_next;
      inst_o       <= inst_next;
      inst_valid_o <= inst_valid_next;
      ld_data_o    <= ld_data_next;
      ld_valid_o   <= ld_valid_next;
      st_data_o    <= st_data_next;
      st_done_o    <= st_done_next;
      st_timeout_o <= st_timeout_next;
      cmd_ready_o  <= ready_next;
      busy_o       <= busy_next;
`ifdef LEON_SEQ_STORE_CHECK_EN
      st_mismatch_o <= mismatch_next;
`endif
    end
  end

endmodule

// File: tb/tb_leon_stim_sequencer.sv
// tb_leon_stim_sequencer
// Scoreboard bench for leon_stim_sequencer. Commands are pushed together with
// their expected instruction word, load return and store outcome; a negedge
// monitor pops and compares as the design produces strobes. The monitor also
// plays the pipeline's data-cache write side: a write "at step k" is presented
// in the cycle before step k so it is sampled on the edge that begins step k.
// Honours LEON_SEQ_STORE_CHECK_EN.
`timescale 1ns/1ps
module tb_leon_stim_sequencer;
  import leon_seq_pkg::*;

  localparam logic [31:0] NOP_W = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'd0;
  logic [4:0]  cmd_rd_i = '0, cmd_rs1_i = '0, cmd_rs2_i = '0;
  logic [31:0] cmd_data_i = '0;
  logic        hold_i = 1'b0;
  logic [31:0] inst_o, ld_data_o, st_data_o;
  logic        inst_valid_o, ld_valid_o, st_done_o, st_timeout_o, busy_o;
  logic        dc_wen_i = 1'b0;
  logic [31:0] dc_wdata_i = '0;
`ifdef LEON_SEQ_STORE_CHECK_EN
  logic        st_mismatch_o;
`endif

  always #5 clk = ~clk;

  leon_stim_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_rd_i     (cmd_rd_i),
    .cmd_rs1_i    (cmd_rs1_i),
    .cmd_rs2_i    (cmd_rs2_i),
    .cmd_data_i   (cmd_data_i),
    .hold_i       (hold_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .ld_data_o    (ld_data_o),
    .ld_valid_o   (ld_valid_o),
    .dc_wen_i     (dc_wen_i),
    .dc_wdata_i   (dc_wdata_i),
    .st_data_o    (st_data_o),
    .st_done_o    (st_done_o),
    .st_timeout_o (st_timeout_o),
`ifdef LEON_SEQ_STORE_CHECK_EN
    .st_mismatch_o(st_mismatch_o),
`endif
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [31:0] word;
    int          gap;      // expected cycles since previous issue, 0 = unchecked
    bit          first;    // expect issue exactly one cycle after acceptance
    int          acc;      // cycle number of the accepting edge
    int          wr_k;     // step of the pipeline's store write, 0 = none
    logic [31:0] wr_data;
    int          wr2_k;
    logic [31:0] wr2_data;
  } inst_exp_t;

  typedef struct {
    bit          timeout;
    logic [31:0] data;
    int          k;
    bit          mis;
  } st_exp_t;

  inst_exp_t   inst_q[$];
  logic [31:0] ld_q[$];
  st_exp_t     st_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int issue_cyc = -100;
  int issue_cnt = 0;
  int cur_wr_k = 0, cur_wr2_k = 0;
  logic [31:0] cur_wr_data = '0, cur_wr2_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_word(input seq_op_e op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] w;
    case (op)
      OP_NOP:  w = 32'h0100_0000;
      OP_LOAD: w = 32'hC000_2000 + (32'(rd) << 25);
      OP_ADD:  w = 32'h8000_0000 + (32'(rd) << 25) + (32'(rs1) << 14) + 32'(rs2);
      default: w = 32'hC020_2000 + (32'(rd) << 25);
    endcase
    return w;
  endfunction

  // Monitor / scoreboard and pipeline write model
  always @(negedge clk) begin : mon
    inst_exp_t e;
    st_exp_t   s;
    int        since;
    logic [31:0] d;
    since = cyc - issue_cyc;
    if (!rst) begin
      if (inst_valid_o) begin
        if (inst_q.size() == 0) chk("inst_unexpected", 1, 0);
        else begin
          e = inst_q.pop_front();
          chk("inst_word", inst_o, e.word);
          if (e.gap > 0) chk("issue_gap", 32'(since), 32'(e.gap));
          if (e.first) chk("issue_latency", 32'(cyc - e.acc), 1);
          cur_wr_k = e.wr_k;  cur_wr_data = e.wr_data;
          cur_wr2_k = e.wr2_k; cur_wr2_data = e.wr2_data;
          $display("issue   cyc=%0d inst=0x%08h", cyc, inst_o);
        end
        issue_cyc = cyc;
        since = 0;
        issue_cnt++;
      end else if (since >= 1 && since <= 4) begin
        chk("pad_nop", inst_o, NOP_W);
      end
      if (ld_valid_o) begin
        if (ld_q.size() == 0) chk("ld_unexpected", 1, 0);
        else begin
          d = ld_q.pop_front();
          chk("ld_data", ld_data_o, d);
          chk("ld_latency", 32'(since), 3);
          $display("load    cyc=%0d data=0x%08h", cyc, ld_data_o);
        end
      end
      if (st_done_o || st_timeout_o) begin
        if (st_q.size() == 0) chk("st_unexpected", 1, 0);
        else begin
          s = st_q.pop_front();
          chk("st_timeout", 32'(st_timeout_o), 32'(s.timeout));
          chk("st_done", 32'(st_done_o), 32'(!s.timeout));
          if (!s.timeout) chk("st_data", st_data_o, s.data);
          chk("st_step", 32'(since), 32'(s.k));
`ifdef LEON_SEQ_STORE_CHECK_EN
          chk("st_mismatch", 32'(st_mismatch_o), 32'(s.mis));
`endif
          $display("store   cyc=%0d done=%0b timeout=%0b data=0x%08h",
                   cyc, st_done_o, st_timeout_o, st_data_o);
        end
      end
`ifdef LEON_SEQ_STORE_CHECK_EN
      if (st_mismatch_o && !st_done_o) chk("mismatch_unexpected", 1, 0);
`endif
    end
    // Pipeline write side
    dc_wen_i   = 1'b0;
    dc_wdata_i = $urandom;
    if (cur_wr_k > 0 && since == cur_wr_k - 1) begin
      dc_wen_i = 1'b1; dc_wdata_i = cur_wr_data;
    end else if (cur_wr2_k > 0 && since == cur_wr2_k - 1) begin
      dc_wen_i = 1'b1; dc_wdata_i = cur_wr2_data;
    end
  end

  task automatic push_cmd(input seq_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] data, input int gap,
                          input bit first, input int wr_k, input logic [31:0] wr_data,
                          input int wr2_k, input logic [31:0] wr2_data);
    inst_exp_t e;
    st_exp_t   s;
    int        n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) begin
      chk("push_ready_timeout", 0, 1);
      return;
    end
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_rd_i    = rd;
    cmd_rs1_i   = rs1;
    cmd_rs2_i   = rs2;
    cmd_data_i  = data;
    e.word = model_word(op, rd, rs1, rs2);
    e.gap = gap; e.first = first; e.acc = cyc + 1;
    e.wr_k = wr_k; e.wr_data = wr_data; e.wr2_k = wr2_k; e.wr2_data = wr2_data;
    inst_q.push_back(e);
    if (op == OP_LOAD) ld_q.push_back(data);
    if (op == OP_STORE) begin
      s.timeout = (wr_k == 0);
      s.data    = wr_data;
      s.k       = (wr_k == 0) ? 4 : wr_k;
      s.mis     = (wr_data != data);
      st_q.push_back(s);
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    $display("push    cyc=%0d op=%0d rd=%0d data=0x%08h", cyc, op, rd, data);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy_o), 0);
  endtask

  initial begin : stim
    int base, n;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_inst", inst_o, NOP_W);
    chk("rst_ready", 32'(cmd_ready_o), 1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_strobes", {28'd0, inst_valid_o, ld_valid_o, st_done_o, st_timeout_o}, 0);
    chk("rst_ld_data", ld_data_o, 0);
    chk("rst_st_data", st_data_o, 0);
`ifdef LEON_SEQ_STORE_CHECK_EN
    chk("rst_mismatch", 32'(st_mismatch_o), 0);
`endif

    // LOAD rd=1 data=5 (rs fields set to show they are ignored)
    push_cmd(OP_LOAD, 5'd1, 5'd9, 5'd17, 32'd5, 0, 1'b1, 0, '0, 0, '0);
    wait_idle();
    chk("ld_data_holds", ld_data_o, 32'd5);

    // STORE rd=3 expecting 7, pipeline writes 8 at k=2 then 9 at k=3 (ignored)
    push_cmd(OP_STORE, 5'd3, 5'd0, 5'd0, 32'd7, 0, 1'b1, 2, 32'd8, 3, 32'd9);
    wait_idle();
    chk("st_data_holds", st_data_o, 32'd8);
    // STORE with no write: timeout at k=4
    push_cmd(OP_STORE, 5'd5, 5'd0, 5'd0, 32'd0, 0, 1'b1, 0, '0, 0, '0);
    wait_idle();
    // STORE whose write lands on the last window step with the expected value
    push_cmd(OP_STORE, 5'd0, 5'd0, 5'd0, 32'h55, 0, 1'b1, 4, 32'h55, 0, '0);
    wait_idle();

    // Five back-to-back commands into a 4-deep FIFO, hold during 2nd PAD
    base = issue_cnt;
    push_cmd(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1'b1, 0, '0, 0, '0);
    push_cmd(OP_ADD, 5'd31, 5'd31, 5'd31, 32'd0, 5, 1'b0, 0, '0, 0, '0);
    push_cmd(OP_ADD, 5'd4, 5'd0, 5'd7, 32'd0, 8, 1'b0, 0, '0, 0, '0);
    push_cmd(OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 5, 1'b0, 0, '0, 0, '0);
    chk("ready_not_full", 32'(cmd_ready_o), 1);
    push_cmd(OP_LOAD, 5'd31, 5'd0, 5'd0, 32'hDEAD_BEEF, 5, 1'b0, 0, '0, 0, '0);
    chk("ready_full", 32'(cmd_ready_o), 0);
    n = 0;
    while (issue_cnt < base + 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("second_issue_seen", 32'(issue_cnt >= base + 2), 1);
    @(posedge clk);
    #1 hold_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold_i = 1'b0;
    wait_idle();

    // Reset in the middle of PAD with a second command still queued
    push_cmd(OP_LOAD, 5'd2, 5'd0, 5'd0, 32'hAA, 0, 1'b1, 0, '0, 0, '0);
    push_cmd(OP_ADD, 5'd1, 5'd1, 5'd1, 32'd0, 5, 1'b0, 0, '0, 0, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    inst_q.delete();
    ld_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_ready", 32'(cmd_ready_o), 1);
    chk("midrst_strobes", {28'd0, inst_valid_o, ld_valid_o, st_done_o, st_timeout_o}, 0);
    repeat (10) @(negedge clk);
    chk("midrst_still_idle", 32'(busy_o), 0);

    // Everything expected must have been produced
    chk("inst_q_drained", 32'(inst_q.size()), 0);
    chk("ld_q_drained", 32'(ld_q.size()), 0);
    chk("st_q_drained", 32'(st_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
